// File: rtl/sig_table_loader_pkg.sv
// Shared definitions for the sigmoid activation table loader and reader.
//   - state_t     : loader FSM states
//   - table_size  : number of entries in a table with a given address width
//   - offset_bin  : two's-complement code -> offset-binary address (MSB invert)
package sig_table_loader_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  localparam int unsigned DEF_IN_W = 10;

  function automatic int unsigned table_size(input int unsigned w);
    return 32'd1 << w;
  endfunction

  localparam int unsigned DEF_TABLE_SIZE = table_size(DEF_IN_W);

  // Reader addresses entry x at x + 2^(w-1) (mod 2^w); for a two's-complement
  // code that is just the code with its sign bit flipped.
  function automatic int unsigned offset_bin(input int unsigned code, input int unsigned w);
    return code ^ (32'd1 << (w - 32'd1));
  endfunction

endpackage

// File: rtl/sig_table_loader_if.sv
// Valid/ready entry stream feeding the table loader.
//   in_valid : source entry valid            (master -> slave)
//   in_data  : source entry value            (master -> slave)
//   in_ready : loader accepts entry this cycle (slave -> master)
interface sig_table_loader_if #(
  parameter int unsigned dataWidth = 16
);
  import sig_table_loader_pkg::*;

  logic                 in_valid;
  logic [dataWidth-1:0] in_data;
  logic                 in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/sig_table_loader.sv
// Writer side of the sigmoid activation LUT. Accepts 2^inWidth entries over a
// valid/ready stream and drives the table memory's synchronous write port,
// generating offset-binary addresses for either source ordering.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   load_start        : pulse, begins a full-table load (IDLE only)
//   load_abort        : pulse, cancels an in-progress load
//   src               : entry stream (in_valid / in_data / in_ready)
//   wr_en/addr/data   : memory write port, one cycle after each handshake
//   busy              : load in progress
//   table_valid       : table fully loaded since last start/abort/reset
//   load_done         : pulse coinciding with the final entry's write
module sig_table_loader
  import sig_table_loader_pkg::*;
#(
  parameter int unsigned inWidth   = DEF_IN_W,
  parameter int unsigned dataWidth = 16,
  parameter int unsigned srcOrder  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_start,
  input  logic                 load_abort,
  sig_table_loader_if.slave    src,
  output logic                 wr_en,
  output logic [inWidth-1:0]   wr_addr,
  output logic [dataWidth-1:0] wr_data,
  output logic                 busy,
  output logic                 table_valid,
  output logic                 load_done
);

  localparam logic [inWidth-1:0] LAST_IDX = inWidth'(table_size(inWidth) - 32'd1);

  state_t             state;
  state_t             state_nxt;
  logic [inWidth-1:0] cnt;
  logic [inWidth-1:0] addr_map;
  logic               accept;
  logic               last_entry;
  logic               start_ok;

  // Abort wins over a same-cycle handshake: that entry is dropped.
  assign accept     = src.in_valid && src.in_ready && !load_abort;
  assign last_entry = (cnt == LAST_IDX);
  assign start_ok   = (state == ST_IDLE) && load_start;

  generate
    if (srcOrder == 1) begin : g_code_order
      assign addr_map = inWidth'(offset_bin(32'(cnt), inWidth));
    end else begin : g_ascending
      assign addr_map = cnt;
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (load_start) state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (load_abort)                 state_nxt = ST_IDLE;
        else if (accept && last_entry)  state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; in_ready never depends on in_valid.
  always_comb begin
    src.in_ready = (state == ST_LOAD);
    busy         = (state == ST_LOAD);
  end

  // Write stage: registered one cycle after the handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      table_valid <= 1'b0;
      load_done   <= 1'b0;
    end else begin
      wr_en     <= accept;
      load_done <= accept && last_entry;
      if (start_ok) begin
        cnt         <= '0;
        table_valid <= 1'b0;
      end else if (accept) begin
        cnt     <= last_entry ? '0 : cnt + 1'b1;
        wr_addr <= addr_map;
        wr_data <= src.in_data;
        if (last_entry) table_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sig_table_loader.sv
module tb_sig_table_loader;

  localparam int IW = 4;
  localparam int DW = 16;
  localparam int N  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic load_start = 1'b0;
  logic load_abort = 1'b0;

  sig_table_loader_if #(.dataWidth(DW)) s0 ();
  sig_table_loader_if #(.dataWidth(DW)) s1 ();

  logic          wr_en0, wr_en1, busy0, busy1, tv0, tv1, ld0, ld1;
  logic [IW-1:0] wr_addr0, wr_addr1;
  logic [DW-1:0] wr_data0, wr_data1;

  sig_table_loader #(.inWidth(IW), .dataWidth(DW), .srcOrder(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_abort(load_abort),
    .src(s0.slave), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .busy(busy0), .table_valid(tv0), .load_done(ld0));

  sig_table_loader #(.inWidth(IW), .dataWidth(DW), .srcOrder(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_abort(load_abort),
    .src(s1.slave), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .busy(busy1), .table_valid(tv1), .load_done(ld1));

  initial forever #5 clk = ~clk;

  typedef struct {
    int a0;
    int a1;
    int d;
    bit last;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   total = 0;
  int   bad = 0;
  int   wr_cnt = 0;
  int   done_cnt = 0;
  bit   m_load = 1'b0;
  bit   m_tv = 1'b0;
  int   m_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] d);
    s0.in_valid = v;
    s1.in_valid = v;
    s0.in_data  = d;
    s1.in_data  = d;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wr_en0"}, int'(wr_en0), 0);
    chk({tag, "_wr_en1"}, int'(wr_en1), 0);
    chk({tag, "_wr_addr0"}, int'(wr_addr0), 0);
    chk({tag, "_wr_addr1"}, int'(wr_addr1), 0);
    chk({tag, "_wr_data0"}, int'(wr_data0), 0);
    chk({tag, "_busy0"}, int'(busy0), 0);
    chk({tag, "_in_ready0"}, int'(s0.in_ready), 0);
    chk({tag, "_in_ready1"}, int'(s1.in_ready), 0);
    chk({tag, "_table_valid0"}, int'(tv0), 0);
    chk({tag, "_load_done0"}, int'(ld0), 0);
  endtask

  // One clock: apply inputs, advance the reference model at the edge.
  // The model works in signed-x terms: entry position -> x -> x + N/2.
  task automatic cyc(input bit st, input bit ab, input bit v,
                     input logic [DW-1:0] d, output bit acc);
    exp_t e;
    int   x0, x1;
    load_start = st;
    load_abort = ab;
    drive(v, d);
    @(posedge clk);
    acc = 1'b0;
    if (!m_load) begin
      if (st) begin
        m_load = 1'b1;
        m_cnt  = 0;
        m_tv   = 1'b0;
      end
    end else if (ab) begin
      m_load = 1'b0;
    end else if (v) begin
      x0 = m_cnt - N / 2;
      x1 = (m_cnt < N / 2) ? m_cnt : m_cnt - N;
      e.a0   = x0 + N / 2;
      e.a1   = x1 + N / 2;
      e.d    = int'(d);
      e.last = (m_cnt == N - 1);
      q.push_back(e);
      acc = 1'b1;
      m_cnt++;
      if (m_cnt == N) begin
        m_load = 1'b0;
        m_tv   = 1'b1;
        m_cnt  = 0;
      end
    end
    #1;
    load_start = 1'b0;
    load_abort = 1'b0;
  endtask

  task automatic run_load(input bit sa, input int gap_a, input int gap_b, input int gap_len,
                          input int abort_at, input int restart_at, input bit rnd,
                          input int exp_writes, input int exp_done);
    int          acc_n, guard;
    bit          acc, v;
    logic [DW-1:0] d;
    wr_cnt   = 0;
    done_cnt = 0;
    cyc(1'b1, sa, 1'b0, '0, acc);
    acc_n = 0;
    guard = 0;
    while (m_load && guard < 500) begin
      guard++;
      v = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      d = rnd ? DW'($urandom) : DW'(16'h0100 + acc_n);
      cyc((restart_at == acc_n) && v, (abort_at == acc_n) && v, v, d, acc);
      if (acc) begin
        if (acc_n == gap_a || acc_n == gap_b)
          repeat (gap_len) cyc(1'b0, 1'b0, 1'b0, 16'hDEAD, acc);
        acc_n++;
      end
    end
    if (guard >= 500) chk("load_timeout", guard, 0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, '0, acc);
    chk("write_count", wr_cnt, exp_writes);
    chk("done_count", done_cnt, exp_done);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready0", int'(s0.in_ready), int'(m_load));
      chk("in_ready1", int'(s1.in_ready), int'(m_load));
      chk("busy0", int'(busy0), int'(m_load));
      chk("busy1", int'(busy1), int'(m_load));
      chk("table_valid0", int'(tv0), int'(m_tv));
      chk("table_valid1", int'(tv1), int'(m_tv));
      if (q.size() > 0) begin
        me = q.pop_front();
        chk("wr_en0", int'(wr_en0), 1);
        chk("wr_en1", int'(wr_en1), 1);
        chk("wr_addr0", int'(wr_addr0), me.a0);
        chk("wr_addr1", int'(wr_addr1), me.a1);
        chk("wr_data0", int'(wr_data0), me.d);
        chk("wr_data1", int'(wr_data1), me.d);
        chk("load_done0", int'(ld0), int'(me.last));
        chk("load_done1", int'(ld1), int'(me.last));
      end else begin
        chk("idle_wr_en0", int'(wr_en0), 0);
        chk("idle_wr_en1", int'(wr_en1), 0);
        chk("idle_load_done0", int'(ld0), 0);
        chk("idle_load_done1", int'(ld1), 0);
      end
      if (wr_en0) wr_cnt++;
      if (ld0) done_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int a;
    drive(1'b0, '0);
    #2 rst_n = 1'b0;
    #1 check_zero("reset");
    #29 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // continuous load
    run_load(1'b0, -1, -1, 0, -1, -1, 1'b0, 16, 1);
    chk("tv_after_load", int'(tv0), 1);
    // stalls after entries 2 and 9
    run_load(1'b0, 2, 9, 3, -1, -1, 1'b0, 16, 1);
    // abort on the handshake of entry 5
    run_load(1'b0, -1, -1, 0, 5, -1, 1'b0, 5, 0);
    chk("tv_after_abort", int'(tv0), 0);

    // asynchronous reset after entry 6
    cyc(1'b1, 1'b0, 1'b0, '0, acc);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b1, DW'(16'h0200 + i), acc);
    drive(1'b0, '0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_zero("midreset");
    m_load = 1'b0;
    m_tv   = 1'b0;
    q.delete();
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_load(1'b0, -1, -1, 0, -1, -1, 1'b0, 16, 1);

    // load_start during LOAD ignored
    run_load(1'b0, -1, -1, 0, -1, 10, 1'b0, 16, 1);
    // start and abort together in IDLE: start wins
    run_load(1'b1, -1, -1, 0, -1, -1, 1'b0, 16, 1);

    // randomized loads with random gaps and data
    repeat (3) run_load(1'b0, -1, -1, 0, -1, -1, 1'b1, 16, 1);
    a = $urandom_range(0, N - 1);
    run_load(1'b0, -1, -1, 0, a, -1, 1'b1, a, 0);
    run_load(1'b0, -1, -1, 0, -1, -1, 1'b1, 16, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sig_table_loader.md
Name: sig_table_loader

Overview:
- Writer side of the sigmoid activation lookup table: accepts a stream of table entries over a valid/ready handshake and drives the table memory's synchronous write port.
- Sits between the host/configuration path and the activation LUT memory; replaces the fixed file-load with a runtime load.
- The table reader indexes memory by offset-binary address, so `addr = x + 2^(inWidth-1)` and entry 0 corresponds to x = -2^(inWidth-1).
- The loader produces those addresses from either source ordering.

Parameters:
- inWidth, 10, table address width; the table holds 2^inWidth entries.
- dataWidth, 16, width of one table entry.
- srcOrder, 0, source ordering:
  - 0: entries arrive ascending signed x (-2^(inWidth-1) first).
  - 1: entries arrive in two's-complement code order (x = 0 first).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- load_start  input  1  one-cycle pulse; begins a full-table load
- load_abort  input  1  one-cycle pulse; cancels an in-progress load
- in_valid  input  1  source entry valid
- in_data  input  dataWidth  source entry value
- in_ready  output  1  loader accepts an entry this cycle
- wr_en  output  1  memory write strobe
- wr_addr  output  inWidth  memory write address (offset-binary)
- wr_data  output  dataWidth  memory write data
- busy  output  1  load in progress
- table_valid  output  1  table fully loaded since the last start/abort/reset
- load_done  output  1  one-cycle pulse on completion

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; the entry counter goes to 0.
  - in_ready, wr_en, busy, table_valid and load_done all go to 0.
  - wr_addr and wr_data go to 0.
- States:
  - IDLE -> LOAD on load_start. On this transition: clear the counter, set busy=1, set table_valid=0.
  - LOAD -> IDLE on load_abort. Abort takes priority over any handshake in the same cycle: that entry is not written. table_valid stays 0.
  - LOAD -> IDLE after the handshake of entry 2^inWidth-1. On this transition, table_valid=1 and load_done=1, both registered.
- in_ready:
  - in_ready = 1 only in LOAD.
  - It is combinational from state, so the source may hold in_valid without risk.
- Handshake: an entry transfers when in_valid && in_ready on a rising edge.
- Write port latency:
  - One cycle: wr_en, wr_addr and wr_data are registered and valid in the cycle after the handshake.
  - wr_en is 0 in every other cycle.
- Address mapping, with counter c running 0..2^inWidth-1:
  - srcOrder=0: wr_addr = c.
  - srcOrder=1: wr_addr = c with the MSB inverted. This equals x + 2^(inWidth-1) mod 2^inWidth for x=c as two's complement.
- Counter behaviour:
  - The counter increments per handshake and wraps to 0 only after the final entry.
  - The final entry's write appears on the same cycle as load_done.
- Start during LOAD: load_start is ignored (no restart). It only has effect in IDLE.
- Simultaneous start+abort in IDLE: start wins and abort is ignored.
- Gaps: in_valid gaps of any length are allowed; the counter holds during them.
- Reset mid-load: the partial table is left in memory and table_valid=0. The reader must gate on table_valid.
- Reload: a new load_start after completion clears table_valid until the new load completes.

Decomposition:
- Shared package (used by both loader and reader):
  - The table size constant 2^inWidth.
  - The offset-binary mapping function (MSB invert).
  - The state enum (IDLE, LOAD).
- Sub-module: none needed. The address mapping is a one-line function from the package; the counter and FSM sit in one module.

Test Plan (inWidth=4, dataWidth=16 unless noted):
- Continuous load, srcOrder=0:
  - Stimulus: pulse load_start, hold in_valid=1, in_data = 16'h0100+i for i=0..15.
  - Required: wr_addr = 0..15 with matching data, each one cycle after its handshake.
  - load_done pulses with the entry-15 write; table_valid=1; busy=0.
- srcOrder=1 mapping:
  - Stimulus: same stream as above.
  - Required: entry i=0 is written at addr 8, i=7 at addr 15, i=8 at addr 0, i=15 at addr 7.
- Stalls:
  - Stimulus: deassert in_valid for 3 cycles after entries 2 and 9.
  - Required: no wr_en during gaps, addresses contiguous, exactly 16 writes in total.
- Abort:
  - Stimulus: load_abort in the same cycle as the handshake of entry 5.
  - Required: only addrs 0..4 are written; in_ready=0 next cycle; table_valid=0; no load_done.
- Reset mid-load:
  - Stimulus: drive rst_n=0 asynchronously (off clock edge) after entry 6.
  - Required: all outputs 0 immediately. A following load_start then reloads from addr 0.
- Ignored restart:
  - Stimulus: load_start pulsed at entry 10 during LOAD.
  - Required: the counter continues to 15 and completes normally with a single load_done.
